sig_halt_monitor: RTL and testbench

Synthesizable test-harness peripheral that snoops the core's data-bus store channel in soc_top and captures RISC-V architecture-test traffic. Stores to the signature address are buffered in a FIFO and drained to the simulation signature writer over a valid/ready port. A store to the halt address, or expiry of a programmable cycle budget, ends the run. The block replaces ad-hoc bench-side decoding with one registered, verifiable stage directly downstream of the dbus.

---
 rtl/sig_halt_mon_pkg.sv | 14 +
 rtl/sig_sync_fifo.sv | 73 +++++++
 rtl/sig_halt_monitor.sv | 104 ++++++++++
 tb/tb_sig_halt_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sig_halt_mon_pkg.sv
// Shared definitions for the signature/halt monitor: FSM state type and the
// default test-harness addresses used by soc_top and the bench.
package sig_halt_mon_pkg;

    localparam logic [31:0] DEF_SIG_ADDR  = 32'h001F_FE68;
    localparam logic [31:0] DEF_HALT_ADDR = 32'h001F_FE6C;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } type_sig_mon_state_e;

endpackage

// File: rtl/sig_sync_fifo.sv
// Single-clock FIFO with a registered head word and a separate occupancy
// counter, so full and empty never alias.
module sig_sync_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     valid_o,
    output logic [Width-1:0]         head_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic             valid_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntFull) || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        head_d   = head_q;
        // A push into a FIFO that is (or becomes) empty lands straight in the head.
        if (do_push && ((count_q - CntW'(do_pop)) == '0)) begin
            head_d = data_i;
        end else if (do_pop && (count_q > CntW'(1))) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;

endmodule

// File: rtl/sig_halt_monitor.sv
// Snoops dbus stores: buffers signature words, detects halt or cycle-budget
// expiry, then drains the buffer and parks in DONE until reset.
module sig_halt_monitor
    import sig_halt_mon_pkg::*;
#(
    parameter logic [31:0] SIG_ADDR   = DEF_SIG_ADDR,
    parameter logic [31:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   bus_addr_i,
    input  logic [31:0]                   bus_wdata_i,
    input  logic                          bus_store_req_i,
    output logic                          bus_ack_o,
    input  logic [CNT_W-1:0]              max_cycles_i,
    output logic                          sig_valid_o,
    output logic [31:0]                   sig_data_o,
    input  logic                          sig_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   sig_count_o,
    output logic                          overflow_o,
    output logic                          halt_o,
    output logic                          timeout_o,
    output logic                          done_o,
    output logic [CNT_W-1:0]              cycle_cnt_o
);
    type_sig_mon_state_e state_q, state_d;
    logic             ack_q, halt_q, halt_d, timeout_q, timeout_d;
    logic             overflow_q, overflow_d, done_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_hit, halt_hit, timeout_hit, push, pop;
    logic             fifo_full, fifo_empty;

    assign sig_hit     = bus_store_req_i && (bus_addr_i == SIG_ADDR);
    assign halt_hit    = bus_store_req_i && (bus_addr_i == HALT_ADDR);
    assign timeout_hit = (state_q == RUN) && (max_cycles_i != '0) && (cnt_q == max_cycles_i);
    assign push        = (state_q == RUN) && sig_hit;
    assign pop         = sig_valid_o && sig_ready_i;

    sig_sync_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (bus_wdata_i),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (sig_count_o),
        .valid_o (sig_valid_o),
        .head_o  (sig_data_o)
    );

    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q | (push && fifo_full && !pop);
        cnt_d      = ((state_q != DONE) && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            RUN: begin
                if (halt_hit)    halt_d    = 1'b1;
                if (timeout_hit) timeout_d = 1'b1;
                if (halt_hit || timeout_hit) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !pop) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ack_q      <= 1'b0;
            halt_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= sig_hit || halt_hit;
            halt_q     <= halt_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            done_q     <= (state_d == DONE);
            cnt_q      <= cnt_d;
        end
    end

    assign bus_ack_o   = ack_q;
    assign halt_o      = halt_q;
    assign timeout_o   = timeout_q;
    assign overflow_o  = overflow_q;
    assign done_o      = done_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sig_halt_monitor.sv
// Directed bench for sig_halt_monitor: a vector table for the basic store/halt
// flow plus hand-written sequences for overflow, timeout, drain and reset.
module tb_sig_halt_monitor;
    import sig_halt_mon_pkg::*;

    localparam logic [31:0] OTHER_ADDR = 32'h001F_FE64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_addr_i = '0;
    logic [31:0] bus_wdata_i = '0;
    logic        bus_store_req_i = 1'b0;
    logic        bus_ack_o;
    logic [31:0] max_cycles_i = '0;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        sig_ready_i = 1'b0;
    logic [4:0]  sig_count_o;
    logic        overflow_o, halt_o, timeout_o, done_o;
    logic [31:0] cycle_cnt_o;

    int checks = 0;
    int errors = 0;

    sig_halt_monitor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_addr_i      (bus_addr_i),
        .bus_wdata_i     (bus_wdata_i),
        .bus_store_req_i (bus_store_req_i),
        .bus_ack_o       (bus_ack_o),
        .max_cycles_i    (max_cycles_i),
        .sig_valid_o     (sig_valid_o),
        .sig_data_o      (sig_data_o),
        .sig_ready_i     (sig_ready_i),
        .sig_count_o     (sig_count_o),
        .overflow_o      (overflow_o),
        .halt_o          (halt_o),
        .timeout_o       (timeout_o),
        .done_o          (done_o),
        .cycle_cnt_o     (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        e_ack;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_count;
        logic        e_halt;
        logic        e_done;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] addr, input logic [31:0] data,
                         input logic rdy);
        bus_store_req_i = st;
        bus_addr_i      = addr;
        bus_wdata_i     = data;
        sig_ready_i     = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset(input logic [31:0] max_cyc);
        bus_store_req_i = 1'b0;
        sig_ready_i     = 1'b0;
        max_cycles_i    = max_cyc;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, OTHER_ADDR,    32'h55, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, DEF_SIG_ADDR,  32'hA,  1'b1, 1'b1, 1'b1, 32'hA, 5'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, DEF_SIG_ADDR,  32'hB,  1'b1, 1'b1, 1'b1, 32'hB, 5'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, DEF_SIG_ADDR,  32'hC,  1'b1, 1'b1, 1'b1, 32'hC, 5'd1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, DEF_HALT_ADDR, 32'h1,  1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, DEF_SIG_ADDR,  32'hD,  1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1};

        // Reset values
        do_reset(32'd0);
        chk("rst_ack", 32'(bus_ack_o), 32'd0);
        chk("rst_valid", 32'(sig_valid_o), 32'd0);
        chk("rst_data", sig_data_o, 32'd0);
        chk("rst_count", 32'(sig_count_o), 32'd0);
        chk("rst_flags", {28'd0, overflow_o, halt_o, timeout_o, done_o}, 32'd0);
        chk("rst_cnt", cycle_cnt_o, 32'd0);

        // Basic store/pop/halt flow from the vector table
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].st, vecs[i].addr, vecs[i].data, vecs[i].rdy);
            chk($sformatf("v%0d_ack", i), 32'(bus_ack_o), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_valid", i), 32'(sig_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk($sformatf("v%0d_data", i), sig_data_o, vecs[i].e_data);
            chk($sformatf("v%0d_count", i), 32'(sig_count_o), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_halt", i), 32'(halt_o), 32'(vecs[i].e_halt));
            chk($sformatf("v%0d_done", i), 32'(done_o), 32'(vecs[i].e_done));
        end
        chk("v_cnt_frozen", cycle_cnt_o, 32'd6);

        // Fill to full, simultaneous push+pop at full, then overflow
        do_reset(32'd0);
        for (int i = 0; i < 16; i++) drive(1'b1, DEF_SIG_ADDR, 32'd200 + 32'(i), 1'b0);
        chk("full_count", 32'(sig_count_o), 32'd16);
        chk("full_no_ovf", 32'(overflow_o), 32'd0);
        drive(1'b1, DEF_SIG_ADDR, 32'd216, 1'b1);
        chk("pp_count", 32'(sig_count_o), 32'd16);
        chk("pp_no_ovf", 32'(overflow_o), 32'd0);
        chk("pp_head", sig_data_o, 32'd201);
        drive(1'b1, DEF_SIG_ADDR, 32'd217, 1'b0);
        chk("ovf_ack", 32'(bus_ack_o), 32'd1);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        drive(1'b1, DEF_SIG_ADDR, 32'd218, 1'b0);
        chk("ovf_count", 32'(sig_count_o), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_word%0d", i), sig_data_o, 32'd201 + 32'(i));
            idle(1'b1);
        end
        chk("ovf_empty", 32'(sig_valid_o), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Cycle budget expiry
        do_reset(32'd100);
        repeat (100) idle(1'b0);
        chk("to_cnt100", cycle_cnt_o, 32'd100);
        chk("to_not_yet", 32'(timeout_o), 32'd0);
        idle(1'b0);
        chk("to_set", 32'(timeout_o), 32'd1);
        chk("to_cnt101", cycle_cnt_o, 32'd101);
        chk("to_drain_done0", 32'(done_o), 32'd0);
        idle(1'b0);
        chk("to_done", 32'(done_o), 32'd1);
        repeat (5) idle(1'b0);
        chk("to_cnt_frozen", cycle_cnt_o, 32'd102);
        chk("to_no_halt", 32'(halt_o), 32'd0);

        // Signature store after halt while two words are pending
        do_reset(32'd0);
        drive(1'b1, DEF_SIG_ADDR, 32'h111, 1'b0);
        drive(1'b1, DEF_SIG_ADDR, 32'h222, 1'b0);
        drive(1'b1, DEF_HALT_ADDR, 32'h0, 1'b0);
        chk("dr_halt", 32'(halt_o), 32'd1);
        drive(1'b1, DEF_SIG_ADDR, 32'h333, 1'b0);
        chk("dr_ack", 32'(bus_ack_o), 32'd1);
        chk("dr_count", 32'(sig_count_o), 32'd2);
        chk("dr_no_ovf", 32'(overflow_o), 32'd0);
        chk("dr_w0", sig_data_o, 32'h111);
        idle(1'b1);
        chk("dr_w1", sig_data_o, 32'h222);
        chk("dr_done0", 32'(done_o), 32'd0);
        idle(1'b1);
        chk("dr_empty", 32'(sig_valid_o), 32'd0);
        chk("dr_done1", 32'(done_o), 32'd0);
        idle(1'b1);
        chk("dr_done2", 32'(done_o), 32'd1);

        // Asynchronous reset while draining with five words queued
        do_reset(32'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, DEF_SIG_ADDR, 32'h50 + 32'(i), 1'b0);
        drive(1'b1, DEF_HALT_ADDR, 32'h0, 1'b0);
        idle(1'b0);
        chk("ar_pre_count", 32'(sig_count_o), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(sig_valid_o), 32'd0);
        chk("ar_count", 32'(sig_count_o), 32'd0);
        chk("ar_data", sig_data_o, 32'd0);
        chk("ar_flags", {27'd0, bus_ack_o, overflow_o, halt_o, timeout_o, done_o}, 32'd0);
        chk("ar_cnt", cycle_cnt_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, DEF_SIG_ADDR, 32'h99, 1'b0);
        chk("ar_run_push", 32'(sig_count_o), 32'd1);
        chk("ar_run_data", sig_data_o, 32'h99);
        chk("ar_run_cnt", cycle_cnt_o, 32'd1);
        chk("ar_run_halt", 32'(halt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
